// File: rtl/seqdet_pkg.sv
// Shared helpers for the parameterised serial pattern detector: state width,
// elaboration-time KMP transition table and pattern border length.
package seqdet_pkg;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TBL_W   = MAX_LEN * 2 * 4;

  typedef enum logic {
    DET_RESTART = 1'b0,
    DET_OVERLAP = 1'b1
  } det_mode_e;

  function automatic int unsigned state_w(input int unsigned len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

  // Entry (k, b) at bit offset (k*2+b)*4: longest pattern prefix that is a
  // suffix of prefix_k followed by b, capped at len-1 (the full-match entry
  // therefore holds the longest proper border).
  function automatic logic [TBL_W-1:0] kmp_table(input int unsigned len,
                                                 input logic [MAX_LEN-1:0] pat);
    logic [TBL_W-1:0] tbl;
    logic [MAX_LEN:0] s;
    int unsigned      best;
    logic             ok;
    tbl = '0;
    for (int unsigned k = 0; k < len; k++) begin
      for (int unsigned b = 0; b < 2; b++) begin
        s = '0;
        for (int unsigned j = 0; j < k; j++) s[j] = pat[len-1-j];
        s[k] = (b == 1);
        best = 0;
        for (int unsigned m = 1; (m <= k + 1) && (m < len); m++) begin
          ok = 1'b1;
          for (int unsigned i = 0; i < m; i++)
            if (s[k+1-m+i] != pat[len-1-i]) ok = 1'b0;
          if (ok) best = m;
        end
        tbl[(k*2+b)*4 +: 4] = 4'(best);
      end
    end
    return tbl;
  endfunction

  function automatic int unsigned border_len(input int unsigned len,
                                             input logic [MAX_LEN-1:0] pat);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned m = 1; m < len; m++) begin
      ok = 1'b1;
      for (int unsigned i = 0; i < m; i++)
        if (pat[len-1-i] != pat[m-1-i]) ok = 1'b0;
      if (ok) best = m;
    end
    return best;
  endfunction

endpackage

// File: rtl/seqdet_sat_cnt.sv
// Saturating match counter with synchronous clear and a registered
// saturation flag.
module seqdet_sat_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (inc && !sat_q)
      count_d = count_q + CNT_W'(1);
    sat_d = &count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector: KMP prefix-length FSM with Mealy match pulse,
// selectable overlapping/non-overlapping restart and a saturating match count.
module seq_detector_param
  import seqdet_pkg::*;
#(
  parameter int unsigned         PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]  PATTERN = 5'b11011,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic                        input_pulse,
  input  logic                        clear,
  input  logic                        inp_1,
  input  logic                        in_en,
  input  logic                        overlap_en,
  input  logic                        cnt_clr,
  output logic                        out,
  output logic [state_w(PAT_LEN)-1:0] present_state,
  output logic [CNT_W-1:0]            match_count,
  output logic                        cnt_sat
);

  localparam int unsigned      SW      = state_w(PAT_LEN);
  localparam logic [15:0]      PAT16   = 16'(PATTERN);
  localparam logic [TBL_W-1:0] KMP_TBL = kmp_table(PAT_LEN, PAT16);
  localparam int unsigned      BORDER  = border_len(PAT_LEN, PAT16);
  localparam logic [SW-1:0]    LAST    = SW'(PAT_LEN - 1);

  logic [SW-1:0] state_q, state_d;
  logic [4:0]    row;
  logic [3:0]    nxt;
  logic          hit;
  det_mode_e     mode;

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    mode    = det_mode_e'(overlap_en);
    row     = {4'(state_q), inp_1};
    nxt     = KMP_TBL[{row, 2'b00} +: 4];
    if (in_en) begin
      hit = (state_q == LAST) && (inp_1 == PATTERN[0]);
      // overlap_en only steers the post-match state; other edges follow KMP
      if (hit)
        state_d = (mode == DET_OVERLAP) ? SW'(BORDER) : '0;
      else
        state_d = nxt[SW-1:0];
    end
  end

  always_ff @(posedge input_pulse or negedge clear) begin
    if (!clear)
      state_q <= '0;
    else
      state_q <= state_d;
  end

  seqdet_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk   (input_pulse),
    .rst_n (clear),
    .clr   (cnt_clr),
    .inc   (hit),
    .count (match_count),
    .sat   (cnt_sat)
  );

  assign out           = hit;
  assign present_state = state_q;

endmodule
